// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, forwarding record and the byte-lane merge helper for sram_responder.
package sram_pkg;
  localparam int WORD_W = 32;
  localparam int LANES = 4;
  localparam int LANE_W = 8;
  localparam int CNT_W = 32;
  localparam int ERR_W = 16;
  typedef logic [WORD_W-1:0] word_t;
  typedef struct packed {
    logic bad;
    logic [LANES-1:0] wen;
    word_t wdata;
  } fwd_t;
  function automatic word_t merge(word_t old_w, word_t new_w, logic [LANES-1:0] wen);
    word_t r;
    for (int i = 0; i < LANES; i++)
      r[i*LANE_W +: LANE_W] = wen[i] ? new_w[i*LANE_W +: LANE_W] : old_w[i*LANE_W +: LANE_W];
    return r;
  endfunction
endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: CPU-side instruction and data SRAM ports; master = CPU, slave = memory.
interface sram_responder_if;
  logic inst_sram_en;
  logic [3:0] inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic data_sram_en;
  logic [3:0] data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input inst_sram_rdata, data_sram_rdata
  );
  modport slave (
    input inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output inst_sram_rdata, data_sram_rdata
  );
endinterface

// File: rtl/sram_bank.sv
// sram_bank: one byte lane, one write port and two registered read ports (read-before-write).
module sram_bank #(
  parameter int ADDR_W = 14
) (
  input  logic clk,
  input  logic resetn,
  input  logic we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [7:0] wd,
  input  logic re_a,
  input  logic [ADDR_W-1:0] ra_a,
  output logic [7:0] q_a,
  input  logic re_b,
  input  logic [ADDR_W-1:0] ra_b,
  output logic [7:0] q_b
);
  logic [7:0] mem [2**ADDR_W];
  // the array is never cleared; sharing the reset sensitivity drops a write at an edge seen in reset
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      if (we) mem[wa] <= wd;
      if (re_a) q_a <= mem[ra_a];
      if (re_b) q_b <= mem[ra_b];
    end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: dual-port word SRAM with write-first/cross-port forwarding and saturating counters.
// Optional bounds checking against BASE_ADDR with `define SRAM_BOUNDS_CHECK_EN.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter logic [31:0] BASE_ADDR = 32'hbfc0_0000,
  parameter string INIT_FILE = ""
) (
  input  logic clk,
  input  logic resetn,
  sram_responder_if.slave bus,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic err_flag
);
  logic [ADDR_W-1:0] ia, da;
  logic ok_i, ok_d, rd, wr, we, hit;
  word_t qi, qd;
  fwd_t fi, fd;
  logic unused_bits;
  assign ia = bus.inst_sram_addr[ADDR_W+1:2];
  assign da = bus.data_sram_addr[ADDR_W+1:2];
`ifdef SRAM_BOUNDS_CHECK_EN
  assign ok_i = bus.inst_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  assign ok_d = bus.data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
`else
  assign ok_i = 1'b1;
  assign ok_d = 1'b1;
`endif
  assign rd = bus.data_sram_en && bus.data_sram_wen == '0;
  assign wr = bus.data_sram_en && bus.data_sram_wen != '0;
  assign we = wr && ok_d;
  assign hit = bus.inst_sram_en && we && ia == da;
  assign unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata, bus.inst_sram_addr[1:0],
                         bus.data_sram_addr[1:0], bus.inst_sram_addr[31:ADDR_W+2],
                         bus.data_sram_addr[31:ADDR_W+2], BASE_ADDR, INIT_FILE != ""};
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sram_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk(clk), .resetn(resetn),
      .we(we && bus.data_sram_wen[l]), .wa(da), .wd(bus.data_sram_wdata[l*LANE_W +: LANE_W]),
      .re_a(bus.inst_sram_en), .ra_a(ia), .q_a(qi[l*LANE_W +: LANE_W]),
      .re_b(bus.data_sram_en), .ra_b(da), .q_b(qd[l*LANE_W +: LANE_W])
    );
  end
  // banks read the old word; the captured store is merged on top afterwards
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      fi <= '0;
      fd <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (bus.inst_sram_en) fi <= '{bad: !ok_i, wen: hit ? bus.data_sram_wen : 4'h0, wdata: bus.data_sram_wdata};
      if (bus.data_sram_en) fd <= '{bad: !ok_d, wen: bus.data_sram_wen, wdata: bus.data_sram_wdata};
      if (rd && !(&rd_cnt)) rd_cnt <= rd_cnt + 1'b1;
      if (wr && !(&wr_cnt)) wr_cnt <= wr_cnt + 1'b1;
    end
  assign bus.inst_sram_rdata = fi.bad ? '0 : merge(qi, fi.wdata, fi.wen);
  assign bus.data_sram_rdata = fd.bad ? '0 : merge(qd, fd.wdata, fd.wen);
`ifdef SRAM_BOUNDS_CHECK_EN
  logic [1:0] bad_n;
  logic [ERR_W:0] err_sum;
  assign bad_n = {1'b0, bus.inst_sram_en && !ok_i} + {1'b0, bus.data_sram_en && !ok_d};
  assign err_sum = {1'b0, err_cnt} + {{(ERR_W-1){1'b0}}, bad_n};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      err_cnt <= '0;
      err_flag <= 1'b0;
    end else begin
      err_cnt <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
      err_flag <= err_flag || bad_n != 2'd0;
    end
`else
  assign err_cnt = '0;
  assign err_flag = 1'b0;
`endif
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed vector table, hold/reset sequences and random traffic vs a word-level model.
module tb_sram_responder;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [31:0] rd_cnt, wr_cnt;
  logic [15:0] err_cnt;
  logic err_flag;
  sram_responder_if bus();
  sram_responder dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt), .err_flag(err_flag)
  );
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [31:0] mm [int];
  bit kn [int];
  logic [31:0] exp_i = '0, exp_d = '0;
  bit ki = 1'b1, kd = 1'b1;
  int m_rd = 0, m_wr = 0, m_err = 0;
  bit m_flag = 1'b0;
`ifdef SRAM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  typedef struct {
    bit ien; logic [31:0] ia;
    bit den; logic [3:0] dw; logic [31:0] da, dd;
    logic [31:0] ei, ed; bit ci, cd;
  } vec_t;
  vec_t v [11];

  function automatic bit win(input logic [31:0] a);
    return !BC || a[31:16] == 16'hbfc0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit ien, input logic [31:0] ia, input bit den, input logic [3:0] dw,
                       input logic [31:0] da, input logic [31:0] dd);
    bus.inst_sram_en = ien;
    bus.inst_sram_addr = ia;
    bus.inst_sram_wen = 4'hF;
    bus.inst_sram_wdata = $urandom;
    bus.data_sram_en = den;
    bus.data_sram_wen = dw;
    bus.data_sram_addr = da;
    bus.data_sram_wdata = dd;
  endtask

  // word-level behaviour at one accepted edge
  task automatic model(input bit ien, input logic [31:0] ia, input bit den, input logic [3:0] dw,
                       input logic [31:0] da, input logic [31:0] dd);
    int xi, xd, bad;
    logic [31:0] w;
    bit k;
    xi = int'(ia[15:2]);
    xd = int'(da[15:2]);
    bad = 0;
    if (den) begin
      if (!win(da)) bad++;
      if (dw != 4'h0) begin
        m_wr++;
        if (win(da)) begin
          w = mm.exists(xd) ? mm[xd] : 32'h0;
          k = (kn.exists(xd) && kn[xd]) || dw == 4'hF;
          for (int l = 0; l < 4; l++) if (dw[l]) w[l*8 +: 8] = dd[l*8 +: 8];
          mm[xd] = w;
          kn[xd] = k;
          exp_d = w;
          kd = k;
        end else begin
          exp_d = '0;
          kd = 1'b1;
        end
      end else begin
        m_rd++;
        exp_d = (win(da) && mm.exists(xd)) ? mm[xd] : '0;
        kd = !win(da) || (kn.exists(xd) && kn[xd]);
      end
    end
    if (ien) begin
      if (!win(ia)) bad++;
      exp_i = (win(ia) && mm.exists(xi)) ? mm[xi] : '0;
      ki = !win(ia) || (kn.exists(xi) && kn[xi]);
    end
    m_err = (m_err + bad > 65535) ? 65535 : m_err + bad;
    if (bad != 0) m_flag = 1'b1;
  endtask

  task automatic cyc(input bit ien, input logic [31:0] ia, input bit den, input logic [3:0] dw,
                     input logic [31:0] da, input logic [31:0] dd);
    drive(ien, ia, den, dw, da, dd);
    @(posedge clk);
    model(ien, ia, den, dw, da, dd);
    #1;
  endtask

  task automatic cmp_model();
    if (ki) chk("inst_rdata", bus.inst_sram_rdata, exp_i);
    if (kd) chk("data_rdata", bus.data_sram_rdata, exp_d);
  endtask

  task automatic cmp_cnt(input string tag);
    chk({tag, " rd_cnt"}, rd_cnt, m_rd);
    chk({tag, " wr_cnt"}, wr_cnt, m_wr);
    chk({tag, " err_cnt"}, {16'h0, err_cnt}, m_err);
    chk({tag, " err_flag"}, {31'h0, err_flag}, {31'h0, m_flag});
  endtask

  task automatic cmp_zero(input string tag);
    chk({tag, " inst_rdata"}, bus.inst_sram_rdata, '0);
    chk({tag, " data_rdata"}, bus.data_sram_rdata, '0);
    chk({tag, " rd_cnt"}, rd_cnt, '0);
    chk({tag, " wr_cnt"}, wr_cnt, '0);
    chk({tag, " err_cnt"}, {16'h0, err_cnt}, '0);
    chk({tag, " err_flag"}, {31'h0, err_flag}, '0);
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] b;
    b = ($urandom_range(0, 7) == 0) ? 32'h8000_0100 : 32'hbfc0_0100;
    return b + ($urandom_range(0, 7) << 2);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] alias_rd, alias_wr, after_wr, a, old0;
    alias_rd = BC ? 32'h0 : 32'h1234_BB78;
    alias_wr = BC ? 32'h0 : 32'h0BAD_F00D;
    after_wr = BC ? 32'h1234_BB78 : 32'h0BAD_F00D;
    v[0]  = '{0, 32'h0, 1, 4'hF, 32'hbfc0_0010, 32'h1234_5678, 32'h0, 32'h1234_5678, 0, 1};
    v[1]  = '{0, 32'h0, 1, 4'h0, 32'hbfc0_0010, 32'h0, 32'h0, 32'h1234_5678, 0, 1};
    v[2]  = '{0, 32'h0, 1, 4'h2, 32'hbfc0_0010, 32'hAAAA_BBCC, 32'h0, 32'h1234_BB78, 0, 1};
    v[3]  = '{0, 32'h0, 1, 4'h0, 32'hbfc0_0010, 32'h0, 32'h0, 32'h1234_BB78, 0, 1};
    v[4]  = '{1, 32'hbfc0_0020, 1, 4'hF, 32'hbfc0_0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1};
    v[5]  = '{0, 32'hbfc0_0010, 0, 4'hF, 32'hbfc0_0010, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1};
    v[6]  = '{1, 32'hbfc0_0010, 1, 4'h0, 32'hbfc0_0020, 32'h0, 32'h1234_BB78, 32'hDEAD_BEEF, 1, 1};
    v[7]  = '{1, 32'hbfc0_0020, 1, 4'h9, 32'hbfc0_0020, 32'h1122_3344, 32'h11AD_BE44, 32'h11AD_BE44, 1, 1};
    v[8]  = '{0, 32'h0, 1, 4'h0, 32'h8000_0010, 32'h0, 32'h0, alias_rd, 0, 1};
    v[9]  = '{0, 32'h0, 1, 4'hF, 32'h8000_0010, 32'h0BAD_F00D, 32'h0, alias_wr, 0, 1};
    v[10] = '{0, 32'h0, 1, 4'h0, 32'hbfc0_0010, 32'h0, 32'h0, after_wr, 0, 1};
    drive(0, 0, 0, 0, 0, 0);
    #1 resetn = 1'b0;
    #2 cmp_zero("reset");
    @(posedge clk); #1 resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cyc(v[i].ien, v[i].ia, v[i].den, v[i].dw, v[i].da, v[i].dd);
      if (v[i].ci) chk($sformatf("vec%0d inst", i), bus.inst_sram_rdata, v[i].ei);
      if (v[i].cd) chk($sformatf("vec%0d data", i), bus.data_sram_rdata, v[i].ed);
    end
    chk("vec rd_cnt", rd_cnt, 32'd5);
    chk("vec wr_cnt", wr_cnt, 32'd5);
    cmp_cnt("vec");

    cyc(1, 32'hbfc0_0020, 0, 4'h0, 32'h0, 32'h0);
    chk("hold fetch", bus.inst_sram_rdata, 32'h11AD_BE44);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'hbfc0_0020, 1, 4'hF, 32'hbfc0_0020, 32'h5000_0000 + i);
      chk($sformatf("hold inst %0d", i), bus.inst_sram_rdata, 32'h11AD_BE44);
      chk($sformatf("hold data %0d", i), bus.data_sram_rdata, 32'h5000_0000 + i);
    end
    cyc(1, 32'hbfc0_0020, 0, 4'h0, 32'h0, 32'h0);
    chk("refetch", bus.inst_sram_rdata, 32'h5000_0002);

    cyc(1, 32'h8000_0040, 1, 4'h0, 32'h9000_0000, 32'h0);
    cmp_model();
    cmp_cnt("both oow");

    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 4'hF, 32'hbfc0_0100 + i * 4, $urandom);
      cmp_model();
    end
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 1) == 1, raddr(), $urandom_range(0, 3) != 0,
          ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0, raddr(), $urandom);
      cmp_model();
    end
    cmp_cnt("random");

    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'hF, 32'hbfc0_0104 + i * 4, $urandom);
    old0 = mm[64];
    drive(1, 32'hbfc0_0100, 1, 4'hF, 32'hbfc0_0100, 32'hFFFF_0000);
    #3 resetn = 1'b0;
    #2 cmp_zero("async reset");
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0);
    cmp_zero("in reset");
    exp_i = '0; exp_d = '0; m_rd = 0; m_wr = 0; m_err = 0; m_flag = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    cyc(0, 0, 1, 4'h0, 32'hbfc0_0100, 32'h0);
    chk("dropped write", bus.data_sram_rdata, old0);
    for (int i = 0; i < 8; i++) begin
      a = 32'hbfc0_0100 + i * 4;
      cyc(1, a, 1, 4'h0, a, 32'h0);
      cmp_model();
    end
    cmp_cnt("post reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
